// File: rtl/measurement_sequencer.sv
// Measurement sequencer: turns selector command pulses into ADC conversion
// starts, captures the result, and streams it to the UART as two bytes (MSB first).
module measurement_sequencer #(
  parameter int DATA_W         = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_sample,
  input  logic              cmd_send,
  input  logic              cmd_reset,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              tx_busy,
  output logic              adc_start,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              err_timeout,
  output logic [7:0]        sample_count
);

  // Wide enough to hold TIMEOUT_CYCLES-1 even for tiny timeouts.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START, CONV, TX_HI, WAIT_HI, TX_LO, WAIT_LO
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            first, first_nxt;   // first WAIT_* cycle: UART has not raised busy yet

  logic              adc_start_nxt, tx_start_nxt, sample_valid_nxt;
  logic              busy_nxt, err_timeout_nxt;
  logic [7:0]        tx_data_nxt, sample_count_nxt;
  logic [DATA_W-1:0] sample_nxt;
  logic [15:0]       sample_ext;

  assign sample_ext = 16'(sample);

  // State register plus internal timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      first <= first_nxt;
    end
  end

  // Next-state logic; cmd_reset overrides everything.
  always_comb begin
    state_nxt = state;
    if (cmd_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_sample)                     state_nxt = START;
          else if (cmd_send && sample_valid)  state_nxt = TX_HI;
        end
        START:   state_nxt = CONV;
        CONV:    if (adc_done || timer == T_MAX) state_nxt = IDLE;
        TX_HI:   if (!tx_busy) state_nxt = WAIT_HI;
        WAIT_HI: if (!first && !tx_busy) state_nxt = TX_LO;
        TX_LO:   if (!tx_busy) state_nxt = WAIT_LO;
        WAIT_LO: if (!first && !tx_busy) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; pulses are raised one cycle
  // early so they appear in the cycle the FSM sits in the matching state.
  always_comb begin
    adc_start_nxt    = 1'b0;
    tx_start_nxt     = 1'b0;
    tx_data_nxt      = tx_data;
    sample_nxt       = sample;
    sample_valid_nxt = sample_valid;
    err_timeout_nxt  = err_timeout;
    sample_count_nxt = sample_count;
    timer_nxt        = timer;
    first_nxt        = 1'b0;
    busy_nxt         = (state_nxt != IDLE);
    if (cmd_reset) begin
      tx_data_nxt      = '0;
      sample_nxt       = '0;
      sample_valid_nxt = 1'b0;
      err_timeout_nxt  = 1'b0;
      sample_count_nxt = '0;
      timer_nxt        = '0;
    end else begin
      case (state)
        IDLE:  adc_start_nxt = cmd_sample;
        START: timer_nxt = '0;
        CONV: begin
          timer_nxt = timer + 1'b1;
          if (adc_done) begin
            sample_nxt       = adc_data;
            sample_valid_nxt = 1'b1;
            err_timeout_nxt  = 1'b0;
            sample_count_nxt = sample_count + 8'd1;
          end else if (timer == T_MAX) begin
            err_timeout_nxt  = 1'b1;
          end
        end
        TX_HI: if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = sample_ext[15:8];
          first_nxt    = 1'b1;
        end
        TX_LO: if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = sample_ext[7:0];
          first_nxt    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_start    <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
      sample_count <= '0;
    end else begin
      adc_start    <= adc_start_nxt;
      tx_start     <= tx_start_nxt;
      tx_data      <= tx_data_nxt;
      sample       <= sample_nxt;
      sample_valid <= sample_valid_nxt;
      busy         <= busy_nxt;
      err_timeout  <= err_timeout_nxt;
      sample_count <= sample_count_nxt;
    end
  end

endmodule

// File: tb/tb_measurement_sequencer.sv
// Directed bench for measurement_sequencer: vector table for single-cycle
// behaviour plus hand-written sequences for transmit, timeout, abort and wrap.
module tb_measurement_sequencer;

  logic        clk = 1'b0;
  logic        rst, cmd_sample, cmd_send, cmd_reset, adc_done, tx_busy;
  logic [11:0] adc_data;
  logic        adc_start, tx_start, sample_valid, busy, err_timeout;
  logic [7:0]  tx_data, sample_count;
  logic [11:0] sample;

  int pass_cnt = 0;
  int total    = 0;

  measurement_sequencer #(.DATA_W(12), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_sample(cmd_sample), .cmd_send(cmd_send),
    .cmd_reset(cmd_reset), .adc_done(adc_done), .adc_data(adc_data),
    .tx_busy(tx_busy), .adc_start(adc_start), .tx_start(tx_start),
    .tx_data(tx_data), .sample(sample), .sample_valid(sample_valid),
    .busy(busy), .err_timeout(err_timeout), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // UART model: busy from the cycle after tx_start for 10 cycles.
  int ucnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      ucnt    <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      ucnt    <= 9;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  // Monitor: pulse counters, transmitted bytes, tx_data stability.
  int         n_adc = 0;
  int         n_tx  = 0;
  int         stab_err = 0;
  logic [7:0] txq[$];
  logic [7:0] last_byte = 8'h00;
  always @(posedge clk) begin
    if (adc_start) n_adc++;
    if (tx_start) begin
      n_tx++;
      txq.push_back(tx_data);
      last_byte = tx_data;
    end else if (tx_busy && busy && tx_data != last_byte) begin
      stab_err++;
    end
  end

  typedef struct {
    logic        s, d, r, done;
    logic [11:0] data;
    logic [32:0] exp;
  } vec_t;

  function automatic vec_t mk(logic s, logic d, logic r, logic done, logic [11:0] data,
                              logic as, logic ts, logic [7:0] td, logic [11:0] smp,
                              logic sv, logic b, logic e, logic [7:0] c);
    vec_t v;
    v.s = s; v.d = d; v.r = r; v.done = done; v.data = data;
    v.exp = {as, ts, td, smp, sv, b, e, c};
    return v;
  endfunction

  function automatic logic [32:0] outs();
    return {adc_start, tx_start, tx_data, sample, sample_valid, busy, err_timeout, sample_count};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base, k, ok;
    rst = 1'b1; cmd_sample = 0; cmd_send = 0; cmd_reset = 0; adc_done = 0; adc_data = '0;
    step(); step();
    chk("reset_state", 64'(outs()), 64'h0);
    rst = 1'b0;

    //            s d r dn data     as ts td    smp     sv b e cnt
    vt[0]  = mk(0,1,0,0,12'h000, 0,0,8'h0,12'h000,0,0,0,8'd0); // send with no sample: ignored
    vt[1]  = mk(0,0,0,0,12'h000, 0,0,8'h0,12'h000,0,0,0,8'd0);
    vt[2]  = mk(1,0,0,0,12'h000, 1,0,8'h0,12'h000,0,1,0,8'd0); // adc_start next cycle
    vt[3]  = mk(0,0,0,1,12'h123, 0,0,8'h0,12'h000,0,1,0,8'd0); // adc_done in START ignored
    vt[4]  = mk(1,0,0,0,12'h000, 0,0,8'h0,12'h000,0,1,0,8'd0); // sample during CONV dropped
    vt[5]  = mk(0,0,0,0,12'h000, 0,0,8'h0,12'h000,0,1,0,8'd0);
    vt[6]  = mk(0,0,0,0,12'h000, 0,0,8'h0,12'h000,0,1,0,8'd0);
    vt[7]  = mk(0,0,0,1,12'hABC, 0,0,8'h0,12'hABC,1,0,0,8'd1); // capture at n+5
    vt[8]  = mk(1,1,0,0,12'h000, 1,0,8'h0,12'hABC,1,1,0,8'd1); // sample beats send
    vt[9]  = mk(0,0,0,0,12'h000, 0,0,8'h0,12'hABC,1,1,0,8'd1);
    vt[10] = mk(0,0,0,1,12'hABC, 0,0,8'h0,12'hABC,1,0,0,8'd2);
    vt[11] = mk(1,0,1,0,12'h000, 0,0,8'h0,12'h000,0,0,0,8'd0); // reset beats sample
    vt[12] = mk(1,0,0,0,12'h000, 1,0,8'h0,12'h000,0,1,0,8'd0);
    vt[13] = mk(0,0,0,0,12'h000, 0,0,8'h0,12'h000,0,1,0,8'd0);
    vt[14] = mk(0,0,0,1,12'hABC, 0,0,8'h0,12'hABC,1,0,0,8'd1);

    for (int i = 0; i < 15; i++) begin
      cmd_sample = vt[i].s; cmd_send = vt[i].d; cmd_reset = vt[i].r;
      adc_done = vt[i].done; adc_data = vt[i].data;
      step();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(vt[i].exp));
    end
    cmd_sample = 0; cmd_send = 0; cmd_reset = 0; adc_done = 0;

    // Transmit 0xABC: bytes 0A, BC; busy drops 27 cycles after cmd_send.
    base = n_tx;
    txq.delete();
    cmd_send = 1; step(); cmd_send = 0;
    k = 1;
    chk("tx_busy_set", 64'(busy), 64'd1);
    while (busy && k < 100) begin step(); k++; end
    chk("tx_busy_fall_cycle", 64'(k), 64'd27);
    chk("tx_pulses", 64'(n_tx - base), 64'd2);
    chk("tx_byte_hi", 64'(txq.size() > 0 ? txq[0] : 8'hxx), 64'h0A);
    chk("tx_byte_lo", 64'(txq.size() > 1 ? txq[1] : 8'hxx), 64'hBC);
    chk("tx_data_stable", 64'(stab_err), 64'd0);

    // Timeout: adc_start at s, err_timeout visible at s+17, sample kept.
    cmd_sample = 1; step(); cmd_sample = 0;
    chk("to_adc_start", 64'(adc_start), 64'd1);
    repeat (15) step();
    chk("to_err_early", 64'(err_timeout), 64'd0);
    step();
    chk("to_err_s16", 64'({err_timeout, busy}), 64'b01);
    step();
    chk("to_err_set", 64'({err_timeout, busy, sample_valid, sample, sample_count}),
        64'({1'b1, 1'b0, 1'b1, 12'hABC, 8'd1}));
    cmd_sample = 1; step(); cmd_sample = 0; step();
    adc_done = 1; adc_data = 12'h123; step(); adc_done = 0;
    chk("to_err_cleared", 64'({err_timeout, sample_valid, sample, sample_count}),
        64'({1'b0, 1'b1, 12'h123, 8'd2}));

    // Abort during WAIT_HI.
    base = n_tx;
    cmd_send = 1; step(); cmd_send = 0;   // TX_HI
    step();                               // WAIT_HI, tx_start
    step();                               // WAIT_HI
    cmd_reset = 1; step(); cmd_reset = 0;
    chk("abort_state", 64'(outs()), 64'h0);
    repeat (30) step();
    chk("abort_no_tx", 64'(n_tx - base), 64'd1);

    // Async rst mid-CONV.
    cmd_sample = 1; step(); cmd_sample = 0; step();
    adc_done = 1; adc_data = 12'h456; step(); adc_done = 0;
    cmd_sample = 1; step(); cmd_sample = 0; step(); step();
    chk("pre_rst_busy", 64'({busy, sample_valid}), 64'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 64'(outs()), 64'h0);
    #1 rst = 1'b0;
    step();

    // 256 conversions wrap the counter; extra sample pulses in START dropped.
    base = n_adc;
    ok = 1;
    for (int i = 0; i < 256; i++) begin
      cmd_sample = 1; step();
      step();                    // extra cmd_sample seen in START
      cmd_sample = 0; adc_done = 1; adc_data = 12'(i); step(); adc_done = 0;
      if (i == 254) chk("count_255", 64'(sample_count), 64'd255);
    end
    chk("count_wrap", 64'({sample_count, sample}), 64'({8'd0, 12'h0FF}));
    chk("adc_start_count", 64'(n_adc - base), 64'd256);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
